// File: rtl/uart_sample_pkg.sv
// Shared types and helpers for the UART sample link (transmitter and receiver).
package uart_sample_pkg;

    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } byte_state_t;

    typedef enum logic [1:0] {
        F_HUNT,
        F_HI,
        F_LO,
        F_CK
    } frame_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;

    // Integer division: the bit period is truncated, never rounded up.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, byte FSM and bit-period down-counter.
// state   | meaning
// B_IDLE  | waiting for a falling edge on the synchronised line
// B_START | timing to mid start bit; high there means a glitch
// B_DATA  | sampling 8 data bits LSB first, one per bit period
// B_STOP  | timing to mid stop bit; strobes byte_valid or byte_err
module uart_rx_byte
    import uart_sample_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       byte_err
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    logic          sync1;
    logic          sync2;
    logic          rx_prev;
    byte_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          stop_sample;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
            state   <= B_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            sync1   <= rx;
            sync2   <= sync1;
            rx_prev <= sync2;
            case (state)
                B_IDLE: begin
                    if (rx_prev && !sync2) begin
                        state <= B_START;
                        cnt   <= CW'(HALF - 1);
                    end
                end
                B_START: begin
                    if (cnt == '0) begin
                        if (sync2) begin
                            state <= B_IDLE;
                        end else begin
                            state   <= B_DATA;
                            cnt     <= CW'(CLKS_PER_BIT - 1);
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                B_DATA: begin
                    if (cnt == '0) begin
                        shreg <= {sync2, shreg[7:1]};
                        cnt   <= CW'(CLKS_PER_BIT - 1);
                        if (bit_idx == 3'd7) begin
                            state <= B_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                B_STOP: begin
                    // Return to idle at mid-stop so a back-to-back start edge is seen.
                    if (cnt == '0) begin
                        state <= B_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= B_IDLE;
            endcase
        end
    end

    // Strobes are taken straight from the stop sample so the frame layer
    // can register its outputs one cycle after it.
    assign stop_sample = (state == B_STOP) && (cnt == '0);
    assign byte_valid  = stop_sample && sync2;
    assign byte_err    = stop_sample && !sync2;
    assign rx_byte     = shreg;

endmodule

// File: rtl/uart_sample_rx.sv
// UART sample receiver: locks on SYNC_BYTE and rebuilds 16-bit samples.
// Optional checksum byte (hi ^ lo) enabled by `define UART_SAMPLE_RX_CHECKSUM_EN.
// state  | meaning
// F_HUNT | discarding bytes until SYNC_BYTE arrives
// F_HI   | next byte is the sample high byte
// F_LO   | next byte is the sample low byte
// F_CK   | next byte is the checksum (checksum build only)
module uart_sample_rx
    import uart_sample_pkg::*;
#(
    parameter int         CLK_FREQ     = 12000000,
    parameter int         BAUD         = 115200,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_frame_err,
    output logic        o_busy
);

    localparam int CPB       = clks_per_bit(CLK_FREQ, BAUD);
    localparam int TO_CYCLES = TIMEOUT_BITS * CPB;
    localparam int TW        = $clog2(TO_CYCLES);

    logic [7:0]    rx_byte;
    logic          byte_valid;
    logic          byte_err;
    frame_state_t  state;
    logic [7:0]    hi_byte;
`ifdef UART_SAMPLE_RX_CHECKSUM_EN
    logic [7:0]    lo_byte;
`endif
    logic [TW-1:0] tmo;
    logic          timeout;

    uart_rx_byte #(
        .CLKS_PER_BIT(CPB)
    ) u_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (uart_rx),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .byte_err  (byte_err)
    );

    // Idle timer: reloaded on every byte end, counts down only inside a frame
    // and holds at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo <= '0;
        end else if (byte_valid || byte_err) begin
            tmo <= TW'(TO_CYCLES - 1);
        end else if ((state != F_HUNT) && (tmo != '0)) begin
            tmo <= tmo - 1'b1;
        end
    end

    assign timeout = (state != F_HUNT) && (tmo == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= F_HUNT;
            hi_byte     <= '0;
`ifdef UART_SAMPLE_RX_CHECKSUM_EN
            lo_byte     <= '0;
`endif
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            if (byte_err) begin
                o_frame_err <= 1'b1;
                state       <= F_HUNT;
            end else if (byte_valid) begin
                case (state)
                    F_HUNT: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state <= F_HI;
                        end
                    end
                    F_HI: begin
                        hi_byte <= rx_byte;
                        state   <= F_LO;
                    end
                    F_LO: begin
`ifdef UART_SAMPLE_RX_CHECKSUM_EN
                        lo_byte <= rx_byte;
                        state   <= F_CK;
`else
                        o_data  <= {hi_byte, rx_byte};
                        o_valid <= 1'b1;
                        state   <= F_HUNT;
`endif
                    end
`ifdef UART_SAMPLE_RX_CHECKSUM_EN
                    F_CK: begin
                        if (rx_byte == (hi_byte ^ lo_byte)) begin
                            o_data  <= {hi_byte, lo_byte};
                            o_valid <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                        state <= F_HUNT;
                    end
`endif
                    default: state <= F_HUNT;
                endcase
            end else if (timeout) begin
                // A byte completing in the same cycle takes priority (branch above).
                o_frame_err <= 1'b1;
                state       <= F_HUNT;
            end
        end
    end

    assign o_busy = (state != F_HUNT);

endmodule
